payload_match_ctrl: RTL and testbench

PAYLOAD_MATCH_CTRL -- requirements
Module: payload_match_ctrl

---
 rtl/payload_match_ctrl.sv | 157 +++++++++++++++
 tb/tb_payload_match_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_match_ctrl.sv
// Sequencer for a bank of payload-matching engines: clears, streams, drains, captures and reports matches.
// Optional PAYLOAD_MATCH_CNT_EN adds the m_cnt match-count output and a report for zero-match packets.
module payload_match_ctrl #(
    parameter int NUM_ENG   = 16,
    parameter int IDX_W     = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pkt_valid,
    input  logic               pkt_sop,
    input  logic               pkt_eop,
    output logic               pkt_ready,
    output logic               eng_sod,
    output logic               eng_en,
    input  logic [NUM_ENG-1:0] eng_match,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [IDX_W-1:0]   m_idx,
    output logic               m_last,
`ifdef PAYLOAD_MATCH_CNT_EN
    output logic [IDX_W:0]     m_cnt,
`endif
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE,
        SOD,
        STREAM,
        FLUSH,
        CAPTURE,
        REPORT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_ENG-1:0] pending;
    logic [NUM_ENG-1:0] low_bit;
    logic [IDX_W-1:0]   low_idx;
    logic               single_left;
    logic [3:0]         flush_cnt;
    logic               eop_accept;

    assign eop_accept = (state == STREAM) && pkt_valid && pkt_eop;

    // Lowest pending bit as one-hot and as an index; single_left is also true for an empty vector.
    always_comb begin
        low_bit = pending & (~pending + NUM_ENG'(1));
        low_idx = '0;
        for (int unsigned i = NUM_ENG; i > 0; i--) begin
            if (pending[i-1]) begin
                low_idx = IDX_W'(i - 1);
            end
        end
        single_left = (pending & ~low_bit) == '0;
    end

`ifdef PAYLOAD_MATCH_CNT_EN
    logic [IDX_W:0] match_cnt;

    always_comb begin
        match_cnt = '0;
        for (int unsigned i = 0; i < NUM_ENG; i++) begin
            match_cnt = match_cnt + (IDX_W + 1)'(eng_match[i]);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pkt_ready = 1'b0;
        eng_en    = 1'b0;
        eng_sod   = rst;
        m_valid   = 1'b0;
        m_idx     = '0;
        m_last    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (pkt_valid && pkt_sop) begin
                    state_nxt = SOD;
                end
            end
            SOD: begin
                eng_sod   = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                pkt_ready = 1'b1;
                eng_en    = pkt_valid;
                if (eop_accept) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                eng_en = 1'b1;
                if (flush_cnt <= 4'd1) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
`ifdef PAYLOAD_MATCH_CNT_EN
                state_nxt = REPORT;
`else
                state_nxt = (eng_match == '0) ? IDLE : REPORT;
`endif
            end
            REPORT: begin
                m_valid = 1'b1;
                m_idx   = low_idx;
                m_last  = single_left;
                if (m_ready && single_left) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            flush_cnt <= '0;
        end else begin
            if (eop_accept) begin
                flush_cnt <= 4'(FLUSH_CYC);
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt - 4'd1;
            end
            if (state == CAPTURE) begin
                pending <= eng_match;
            end else if (state == REPORT && m_ready) begin
                pending <= pending & ~low_bit;
            end
        end
    end

`ifdef PAYLOAD_MATCH_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= '0;
        end else if (state == CAPTURE) begin
            m_cnt <= match_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_payload_match_ctrl.sv
// Self-checking bench for payload_match_ctrl: directed packets plus randomized packets against a report-queue model.
module tb_payload_match_ctrl;

    localparam int NE = 16;
    localparam int IW = 4;
    localparam int F  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pkt_valid;
    logic          pkt_sop;
    logic          pkt_eop;
    logic          pkt_ready;
    logic          eng_sod;
    logic          eng_en;
    logic [NE-1:0] eng_match;
    logic          m_valid;
    logic          m_ready;
    logic [IW-1:0] m_idx;
    logic          m_last;
    logic          busy;
`ifdef PAYLOAD_MATCH_CNT_EN
    logic [IW:0]   m_cnt;
`endif

    int unsigned checks = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    payload_match_ctrl #(
        .NUM_ENG  (NE),
        .IDX_W    (IW),
        .FLUSH_CYC(F)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pkt_valid(pkt_valid),
        .pkt_sop  (pkt_sop),
        .pkt_eop  (pkt_eop),
        .pkt_ready(pkt_ready),
        .eng_sod  (eng_sod),
        .eng_en   (eng_en),
        .eng_match(eng_match),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_idx    (m_idx),
        .m_last   (m_last),
`ifdef PAYLOAD_MATCH_CNT_EN
        .m_cnt    (m_cnt),
`endif
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_ready"}, 32'(pkt_ready), 0);
        check({tag, "_en"},    32'(eng_en), 0);
        check({tag, "_sod"},   32'(eng_sod), 0);
        check({tag, "_valid"}, 32'(m_valid), 0);
    endtask

    // gap < 0: random 0..2 idle cycles before each beat; otherwise a fixed gap before every beat after the first.
    task automatic run_packet(input int len, input logic [NE-1:0] match, input int gap,
                              input int hold, input bit rnd_ready, input bit abort);
        int q[$];
        int en_beats;
        int guard;
        int rcyc;
        int g;

        pkt_valid = 1'b1;
        pkt_sop   = 1'b1;
        pkt_eop   = (len == 1);
        m_ready   = 1'b0;
        eng_match = NE'($urandom);
        settle;
        check_idle("idle");
        next_cycle;
        settle;
        check("sod_pulse", 32'(eng_sod), 1);
        check("sod_ready", 32'(pkt_ready), 0);
        check("sod_en",    32'(eng_en), 0);
        check("sod_busy",  32'(busy), 1);
        next_cycle;

        en_beats = 0;
        for (int b = 0; b < len; b++) begin
            g = (gap < 0) ? int'($urandom_range(2, 0)) : ((b == 0) ? 0 : gap);
            for (int k = 0; k < g; k++) begin
                pkt_valid = 1'b0;
                pkt_sop   = 1'($urandom);
                pkt_eop   = 1'($urandom);
                settle;
                check("gap_en",    32'(eng_en), 0);
                check("gap_ready", 32'(pkt_ready), 1);
                check("gap_sod",   32'(eng_sod), 0);
                if (eng_en) en_beats++;
                next_cycle;
            end
            pkt_valid = 1'b1;
            pkt_sop   = (b == 0);
            pkt_eop   = (b == len - 1);
            settle;
            check("stream_ready", 32'(pkt_ready), 1);
            check("stream_valid", 32'(m_valid), 0);
            if (eng_en) en_beats++;
            next_cycle;
        end
        check("byte_count", en_beats, len);

        pkt_valid = 1'b0;
        pkt_sop   = 1'b0;
        pkt_eop   = 1'b0;
        for (int f = 0; f < F; f++) begin
            eng_match = NE'($urandom);
            settle;
            check("flush_en",    32'(eng_en), 1);
            check("flush_ready", 32'(pkt_ready), 0);
            check("flush_busy",  32'(busy), 1);
            check("flush_valid", 32'(m_valid), 0);
            next_cycle;
        end

        eng_match = match;
        settle;
        check("cap_en",    32'(eng_en), 0);
        check("cap_valid", 32'(m_valid), 0);
        check("cap_busy",  32'(busy), 1);
        next_cycle;
        eng_match = NE'($urandom);

        for (int i = 0; i < NE; i++) begin
            if (match[i]) q.push_back(i);
        end
`ifdef PAYLOAD_MATCH_CNT_EN
        check("m_cnt", 32'(m_cnt), q.size());
        if (q.size() == 0) q.push_back(0);
`endif
        if (q.size() == 0) begin
            settle;
            check_idle("zero");
            return;
        end

        guard = 0;
        rcyc  = 0;
        while (q.size() > 0 && guard < 200) begin
            m_ready = (rcyc < hold) ? 1'b0 : (rnd_ready ? 1'($urandom) : 1'b1);
            settle;
            check("rep_valid", 32'(m_valid), 1);
            check("rep_idx",   32'(m_idx), q[0]);
            check("rep_last",  32'(m_last), (q.size() == 1) ? 1 : 0);
            check("rep_en",    32'(eng_en), 0);
            check("rep_busy",  32'(busy), 1);
            if (abort) begin
                #1 rst = 1'b1;
                #1;
                check("abort_valid", 32'(m_valid), 0);
                check("abort_sod",   32'(eng_sod), 1);
                check("abort_busy",  32'(busy), 0);
                check("abort_idx",   32'(m_idx), 0);
                #1 rst = 1'b0;
                m_ready = 1'b0;
                next_cycle;
                settle;
                check_idle("post_abort");
                return;
            end
            if (m_ready) void'(q.pop_front());
            next_cycle;
            rcyc++;
            guard++;
        end
        check("report_drained", q.size(), 0);
        m_ready = 1'b0;
        settle;
        check_idle("post");
    endtask

    initial begin
        rst       = 1'b1;
        pkt_valid = 1'b1;
        pkt_sop   = 1'b1;
        pkt_eop   = 1'b0;
        m_ready   = 1'b1;
        eng_match = '1;
        #3;
        check("rst_sod",   32'(eng_sod), 1);
        check("rst_busy",  32'(busy), 0);
        check("rst_ready", 32'(pkt_ready), 0);
        check("rst_en",    32'(eng_en), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_idx",   32'(m_idx), 0);
        check("rst_last",  32'(m_last), 0);
`ifdef PAYLOAD_MATCH_CNT_EN
        check("rst_cnt",   32'(m_cnt), 0);
`endif
        next_cycle;
        next_cycle;
        check("rst_hold_busy", 32'(busy), 0);
        rst       = 1'b0;
        pkt_sop   = 1'b0;
        m_ready   = 1'b0;

        // Non-sop beats in IDLE are held, never start a packet.
        for (int i = 0; i < 3; i++) begin
            next_cycle;
            settle;
            check_idle("hold_nosop");
        end
        next_cycle;

        run_packet(5, 16'h0000, 0, 0, 1'b0, 1'b0);
        run_packet(4, 16'h8021, 0, 0, 1'b0, 1'b0);
        run_packet(3, 16'h0004, 0, 4, 1'b0, 1'b0);
        run_packet(1, 16'h0100, 0, 0, 1'b0, 1'b0);
        run_packet(4, 16'h0ff0, 3, 0, 1'b1, 1'b0);
        run_packet(2, 16'h1234, 0, 0, 1'b0, 1'b1);
        run_packet(1, 16'h0000, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [NE-1:0] mv;
            mv = ($urandom_range(3, 0) == 0) ? '0 : NE'($urandom);
            run_packet(int'($urandom_range(8, 1)), mv, -1, int'($urandom_range(2, 0)),
                       1'b1, ($urandom_range(15, 0) == 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
